hht_rd_arbiter: RTL and testbench

//  Round-robin read arbiter that shares one HHT read memory port between two requesters.

---
 rtl/hht_arb_pkg.sv | 29 ++
 rtl/hht_rd_lat_pipe.sv | 51 +++++
 rtl/hht_rd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_hht_rd_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hht_arb_pkg.sv
// Package: hht_arb_pkg
// Shared types and constants for the HHT read arbiter.
//   req_id_t    - identifies which requester issued a read
//   REQ_COL     - requester 0, column-data fetch (wdata_col_base stream)
//   REQ_VEC     - requester 1, vector-value fetch (v_values_base stream)
//   MAX_RD_LAT  - deepest memory read latency the arbiter supports
//   lat_ent_t   - one slot of the read-latency pipeline {valid, id}
//   sat_inc()   - 32-bit saturating increment used by the optional statistics
//                 counters (HHT_ARB_STATS_EN)
package hht_arb_pkg;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_COL    = 1'b0;
    localparam req_id_t REQ_VEC    = 1'b1;
    localparam int      MAX_RD_LAT = 4;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } lat_ent_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc);
        return (inc && (value != CNT_MAX)) ? value + 32'd1 : value;
    endfunction

endpackage

// File: rtl/hht_rd_lat_pipe.sv
// Module: hht_rd_lat_pipe
// Shift register of {valid, req_id} that tracks reads in flight through the
// memory so each returning mem_rdata word can be tagged with its requester.
// Depth equals the memory read latency (1..MAX_RD_LAT); a zero-latency memory
// needs no tracking and is bypassed by the parent.
// Ports:
//   Clk        in   clock, rising edge
//   Rst        in   asynchronous reset, active-low; flushes all slots
//   in_valid   in   a read was issued to memory this cycle
//   in_id      in   requester that issued it
//   out_valid  out  mem_rdata this cycle belongs to a tracked read
//   out_id     out  requester that read belongs to
module hht_rd_lat_pipe
    import hht_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    Clk,
    input  logic    Rst,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id
);

    lat_ent_t stage_q [RD_LAT];
    lat_ent_t stage_d [RD_LAT];

    always_comb begin
        stage_d[0] = '{valid: in_valid, id: in_id};
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: this array is control state, not data storage: every slot is reset
    // so that reads in flight when Rst asserts can never produce a response.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign out_valid = stage_q[RD_LAT-1].valid;
    assign out_id    = stage_q[RD_LAT-1].id;

endmodule

// File: rtl/hht_rd_arbiter.sv
// Module: hht_rd_arbiter
// Round-robin arbiter sharing one HHT read memory port between the column-data
// fetch (requester 0) and the vector-value fetch (requester 1). Grants are
// combinational, at most one per cycle; each memory response is routed back to
// the requester that issued the read, in issue order, one cycle after the
// memory data arrives.
// Ports:
//   Clk, Rst            clock (rising edge), asynchronous active-low reset
//   arb_en              1 = new grants allowed; 0 = in-flight reads still return
//   reqN, addrN         read request/address, held until gntN
//   gntN                request accepted this cycle (combinational)
//   rvalidN, rdataN     registered response pulse/data; rdataN holds otherwise
//   mem_rd, mem_addr    memory read strobe and address (0 when idle)
//   mem_rdata           memory data, valid RD_LAT cycles after mem_rd
// Optional build macro HHT_ARB_STATS_EN adds saturating 32-bit counters:
//   gnt_cnt0, gnt_cnt1  grants issued to requester 0 / 1
//   conflict_cnt        cycles with req0 & req1 & arb_en
// RD_LAT values above MAX_RD_LAT are clamped to MAX_RD_LAT.
module hht_rd_arbiter
    import hht_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              arb_en,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
`ifdef HHT_ARB_STATS_EN
    output logic [31:0]       gnt_cnt0,
    output logic [31:0]       gnt_cnt1,
    output logic [31:0]       conflict_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int PIPE_DEPTH = (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT;

    // Last granted requester; reset to REQ_VEC so requester 0 wins first.
    req_id_t last_q, last_d;

    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q,  rdata0_d;
    logic [DATA_W-1:0] rdata1_q,  rdata1_d;

    req_id_t iss_id;
    logic    ret_valid;
    req_id_t ret_id;

    // ------------------------------------------------------------------
    // Arbitration and memory request
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        last_d   = last_q;
        mem_addr = '0;

        // Rst gates the grants so nothing is issued while reset is held.
        if (Rst && arb_en) begin
            if (req0 && (!req1 || (last_q == REQ_VEC))) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end

        if (gnt0) begin
            last_d   = REQ_COL;
            mem_addr = addr0;
        end else if (gnt1) begin
            last_d   = REQ_VEC;
            mem_addr = addr1;
        end

        mem_rd = gnt0 | gnt1;
        iss_id = gnt1 ? REQ_VEC : REQ_COL;
    end

    // ------------------------------------------------------------------
    // In-flight tracking: tag aligned with mem_rdata arrival
    // ------------------------------------------------------------------
    generate
        if (PIPE_DEPTH == 0) begin : g_no_pipe
            assign ret_valid = mem_rd;
            assign ret_id    = iss_id;
        end else begin : g_pipe
            hht_rd_lat_pipe #(
                .RD_LAT (PIPE_DEPTH)
            ) u_lat_pipe (
                .Clk       (Clk),
                .Rst       (Rst),
                .in_valid  (mem_rd),
                .in_id     (iss_id),
                .out_valid (ret_valid),
                .out_id    (ret_id)
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response registers
    // ------------------------------------------------------------------
    always_comb begin
        rvalid0_d = ret_valid && (ret_id == REQ_COL);
        rvalid1_d = ret_valid && (ret_id == REQ_VEC);
        rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_q    <= REQ_VEC;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            last_q    <= last_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

`ifdef HHT_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Optional saturating statistics counters
    // ------------------------------------------------------------------
    logic [31:0] gnt_cnt0_q, gnt_cnt0_d;
    logic [31:0] gnt_cnt1_q, gnt_cnt1_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        gnt_cnt0_d     = sat_inc(gnt_cnt0_q, gnt0);
        gnt_cnt1_d     = sat_inc(gnt_cnt1_q, gnt1);
        conflict_cnt_d = sat_inc(conflict_cnt_q, req0 & req1 & arb_en);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            gnt_cnt0_q     <= '0;
            gnt_cnt1_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            gnt_cnt0_q     <= gnt_cnt0_d;
            gnt_cnt1_q     <= gnt_cnt1_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign gnt_cnt0     = gnt_cnt0_q;
    assign gnt_cnt1     = gnt_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_hht_rd_arbiter.sv
// Testbench: tb_hht_rd_arbiter
// Three arbiter instances (RD_LAT = 0, 3, 2) share clock and reset, each with
// its own behavioural memory. A reference model predicts grants and memory
// address every cycle; each predicted grant pushes the expected response (id,
// data, due cycle) onto a per-instance scoreboard queue that is popped when
// the response is due. Statistics ports are checked when HHT_ARB_STATS_EN is
// defined.
module tb_hht_rd_arbiter;

    localparam int NI = 3;
    localparam int LAT [NI] = '{0, 3, 2};

    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic        Clk;
    logic        rst;
    logic        en  [NI];
    logic        r0  [NI];
    logic        r1  [NI];
    logic [31:0] a0  [NI];
    logic [31:0] a1  [NI];
    logic        g0  [NI];
    logic        g1  [NI];
    logic        rv0 [NI];
    logic        rv1 [NI];
    logic [31:0] rd0 [NI];
    logic [31:0] rd1 [NI];
    logic        mrd [NI];
    logic [31:0] maddr  [NI];
    logic [31:0] mrdata [NI];
`ifdef HHT_ARB_STATS_EN
    logic [31:0] gc0 [NI];
    logic [31:0] gc1 [NI];
    logic [31:0] cfc [NI];
    logic [31:0] m_c0 [NI];
    logic [31:0] m_c1 [NI];
    logic [31:0] m_cf [NI];
`endif

    // Reference model state
    rsp_t        sb  [NI][$];
    int          ptr [NI];
    logic [31:0] lr0 [NI];
    logic [31:0] lr1 [NI];
    logic        mg0 [NI];
    logic        mg1 [NI];
    int          cyc;
    int          n_checks;
    int          n_pass;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        case (addr)
            32'd180: return 32'd7;
            32'd181: return 32'd12;
            32'd2:   return 32'd84;
            32'd3:   return 32'd8;
            default: return 32'd99999;
        endcase
    endfunction

    // Behavioural memories: data appears RD_LAT cycles after the address.
    logic [31:0] ap1 [3];
    logic [31:0] ap2 [2];
    always @(posedge Clk) begin
        ap1[0] <= maddr[1];
        ap1[1] <= ap1[0];
        ap1[2] <= ap1[1];
        ap2[0] <= maddr[2];
        ap2[1] <= ap2[0];
    end
    assign mrdata[0] = mem_fn(maddr[0]);
    assign mrdata[1] = mem_fn(ap1[2]);
    assign mrdata[2] = mem_fn(ap2[1]);

    hht_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(0)) u_dut_l0 (
        .Clk(Clk), .Rst(rst), .arb_en(en[0]),
        .req0(r0[0]), .addr0(a0[0]), .gnt0(g0[0]), .rvalid0(rv0[0]), .rdata0(rd0[0]),
        .req1(r1[0]), .addr1(a1[0]), .gnt1(g1[0]), .rvalid1(rv1[0]), .rdata1(rd1[0]),
        .mem_rd(mrd[0]), .mem_addr(maddr[0]),
`ifdef HHT_ARB_STATS_EN
        .gnt_cnt0(gc0[0]), .gnt_cnt1(gc1[0]), .conflict_cnt(cfc[0]),
`endif
        .mem_rdata(mrdata[0])
    );

    hht_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) u_dut_l3 (
        .Clk(Clk), .Rst(rst), .arb_en(en[1]),
        .req0(r0[1]), .addr0(a0[1]), .gnt0(g0[1]), .rvalid0(rv0[1]), .rdata0(rd0[1]),
        .req1(r1[1]), .addr1(a1[1]), .gnt1(g1[1]), .rvalid1(rv1[1]), .rdata1(rd1[1]),
        .mem_rd(mrd[1]), .mem_addr(maddr[1]),
`ifdef HHT_ARB_STATS_EN
        .gnt_cnt0(gc0[1]), .gnt_cnt1(gc1[1]), .conflict_cnt(cfc[1]),
`endif
        .mem_rdata(mrdata[1])
    );

    hht_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2)) u_dut_l2 (
        .Clk(Clk), .Rst(rst), .arb_en(en[2]),
        .req0(r0[2]), .addr0(a0[2]), .gnt0(g0[2]), .rvalid0(rv0[2]), .rdata0(rd0[2]),
        .req1(r1[2]), .addr1(a1[2]), .gnt1(g1[2]), .rvalid1(rv1[2]), .rdata1(rd1[2]),
        .mem_rd(mrd[2]), .mem_addr(maddr[2]),
`ifdef HHT_ARB_STATS_EN
        .gnt_cnt0(gc0[2]), .gnt_cnt1(gc1[2]), .conflict_cnt(cfc[2]),
`endif
        .mem_rdata(mrdata[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at posedge+1 with inputs applied; samples mid-cycle, updates the
    // model, then advances to posedge+1 of the next cycle.
    task automatic tick();
        #4;
        for (int k = 0; k < NI; k++) begin
            logic        e0;
            logic        e1;
            logic        ev0;
            logic        ev1;
            logic        conf;
            logic [31:0] ea;
            rsp_t        r;
            e0   = 1'b0;
            e1   = 1'b0;
            conf = 1'b0;
            if (!rst) begin
                sb[k].delete();
                ptr[k] = 1;
                lr0[k] = '0;
                lr1[k] = '0;
`ifdef HHT_ARB_STATS_EN
                m_c0[k] = '0;
                m_c1[k] = '0;
                m_cf[k] = '0;
`endif
            end else if (en[k]) begin
                conf = r0[k] && r1[k];
                if (conf) begin
                    e0 = (ptr[k] == 1);
                    e1 = (ptr[k] == 0);
                end else begin
                    e0 = r0[k];
                    e1 = r1[k];
                end
            end
            ea = e0 ? a0[k] : (e1 ? a1[k] : 32'd0);
            check($sformatf("i%0d_gnt0", k), 32'(g0[k]), 32'(e0));
            check($sformatf("i%0d_gnt1", k), 32'(g1[k]), 32'(e1));
            check($sformatf("i%0d_mem_rd", k), 32'(mrd[k]), 32'(e0 | e1));
            check($sformatf("i%0d_mem_addr", k), maddr[k], ea);

            ev0 = 1'b0;
            ev1 = 1'b0;
            if (sb[k].size() != 0 && sb[k][0].due == cyc) begin
                r = sb[k].pop_front();
                if (r.id == 0) begin
                    ev0    = 1'b1;
                    lr0[k] = r.data;
                end else begin
                    ev1    = 1'b1;
                    lr1[k] = r.data;
                end
            end
            check($sformatf("i%0d_rvalid0", k), 32'(rv0[k]), 32'(ev0));
            check($sformatf("i%0d_rvalid1", k), 32'(rv1[k]), 32'(ev1));
            check($sformatf("i%0d_rdata0", k), rd0[k], lr0[k]);
            check($sformatf("i%0d_rdata1", k), rd1[k], lr1[k]);

`ifdef HHT_ARB_STATS_EN
            check($sformatf("i%0d_gnt_cnt0", k), gc0[k], m_c0[k]);
            check($sformatf("i%0d_gnt_cnt1", k), gc1[k], m_c1[k]);
            check($sformatf("i%0d_conflict_cnt", k), cfc[k], m_cf[k]);
            if (rst) begin
                if (e0 && m_c0[k] != 32'hFFFF_FFFF) m_c0[k] = m_c0[k] + 1;
                if (e1 && m_c1[k] != 32'hFFFF_FFFF) m_c1[k] = m_c1[k] + 1;
                if (conf && m_cf[k] != 32'hFFFF_FFFF) m_cf[k] = m_cf[k] + 1;
            end
`endif

            if (e0) begin
                sb[k].push_back('{id: 0, data: mem_fn(a0[k]), due: cyc + LAT[k] + 1});
                ptr[k] = 0;
            end
            if (e1) begin
                sb[k].push_back('{id: 1, data: mem_fn(a1[k]), due: cyc + LAT[k] + 1});
                ptr[k] = 1;
            end
            mg0[k] = e0;
            mg1[k] = e1;
        end
        @(posedge Clk);
        cyc++;
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            en[k] = 1'b1;
            r0[k] = 1'b0;
            r1[k] = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] tbl [5];
        tbl = '{32'd180, 32'd181, 32'd2, 32'd3, 32'd50};
        return tbl[$urandom_range(0, 4)];
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        for (int k = 0; k < NI; k++) begin
            ptr[k] = 1;
            lr0[k] = '0;
            lr1[k] = '0;
            mg0[k] = 1'b0;
            mg1[k] = 1'b0;
            en[k]  = 1'b1;
            r0[k]  = 1'b1;
            r1[k]  = 1'b0;
            a0[k]  = 32'd180;
            a1[k]  = 32'd2;
        end
        rst = 1'b0;
        @(posedge Clk);
        #1;

        // 1. Reset held with requests pending, then release: requester 0 first.
        tick();
        tick();
        rst   = 1'b1;
        r1[0] = 1'b1;
        tick();
        idle_all();
        repeat (5) tick();

        // 2. Single requester, zero latency, two addresses.
        r0[0] = 1'b1;
        a0[0] = 32'd180;
        tick();
        a0[0] = 32'd181;
        tick();
        r0[0] = 1'b0;
        repeat (2) tick();

        // 3. Contention after a fresh reset: strict alternation.
        rst = 1'b0;
        tick();
        rst   = 1'b1;
        r0[0] = 1'b1;
        a0[0] = 32'd180;
        r1[0] = 1'b1;
        a1[0] = 32'd2;
        repeat (8) tick();
`ifdef HHT_ARB_STATS_EN
        check("s3_gnt_cnt0", gc0[0], 32'd4);
        check("s3_gnt_cnt1", gc1[0], 32'd4);
        check("s3_conflict_cnt", cfc[0], 32'd8);
`endif
        idle_all();
        repeat (2) tick();

        // 4. RD_LAT=3: requester 1 then requester 0, responses in order.
        r1[1] = 1'b1;
        a1[1] = 32'd3;
        tick();
        r1[1] = 1'b0;
        r0[1] = 1'b1;
        a0[1] = 32'd180;
        tick();
        r0[1] = 1'b0;
        repeat (6) tick();

        // 5. arb_en dropped after a grant: read returns, no grants, pointer kept.
        r0[1] = 1'b1;
        a0[1] = 32'd181;
        tick();
        en[1] = 1'b0;
        r1[1] = 1'b1;
        a1[1] = 32'd3;
        repeat (3) tick();
        en[1] = 1'b1;
        tick();
        r1[1] = 1'b0;
        tick();
        idle_all();
        repeat (5) tick();

        // 6. RD_LAT=2 reads in flight when reset pulses: nothing returns.
        r0[2] = 1'b1;
        a0[2] = 32'd180;
        r1[2] = 1'b1;
        a1[2] = 32'd2;
        tick();
        tick();
        idle_all();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        repeat (5) tick();

        // Random traffic on all instances; pending requests are held.
        repeat (60) begin
            for (int k = 0; k < NI; k++) begin
                if (!(r0[k] && !mg0[k])) begin
                    r0[k] = 1'($urandom_range(0, 1));
                    a0[k] = pick_addr();
                end
                if (!(r1[k] && !mg1[k])) begin
                    r1[k] = 1'($urandom_range(0, 1));
                    a1[k] = pick_addr();
                end
                en[k] = ($urandom_range(0, 7) != 0);
            end
            tick();
        end
        idle_all();
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
